// File: rtl/memacc_tx_if.sv
// -----------------------------------------------------------------------------
// memacc_tx_if
// Request bus between the memory-access request stage (memacc_tx) and the
// data memory / cache.
//
// Signals (mapping to the block-level port names in brackets):
//   req    [mem_req_o]    request to mem/cache, held until gnt
//   we     [mem_we_o]     1 = write, 0 = read
//   addr   [mem_addr_o]   word address, low two bits always 0
//   be     [mem_be_o]     byte enables, be[3] selects bits [31:24] (big endian)
//   wdata  [mem_wdata_o]  store data already placed in its byte lane(s)
//   gnt    [mem_gnt_i]    mem/cache accepts the request this cycle
//
// Modports:
//   master  the request stage (drives req/we/addr/be/wdata, samples gnt)
//   slave   the memory side   (samples the request, drives gnt)
// -----------------------------------------------------------------------------
interface memacc_tx_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;

    modport master (
        output req,
        output we,
        output addr,
        output be,
        output wdata,
        input  gnt
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  be,
        input  wdata,
        output gnt
    );
endinterface : memacc_tx_if

// File: rtl/memacc_tx.sv
// -----------------------------------------------------------------------------
// memacc_tx
// Memory-access request stage between execute and the data mem/cache,
// upstream of memacc_rx. Latches one load/store per cycle, checks alignment,
// builds the word address, big-endian byte enables and lane-placed write data,
// holds the request until granted while stalling the pipeline, and hands the
// read sideband (scope/sign/lsb2) to memacc_rx in the cycle the read data is
// due.
//
// Parameters:
//   TIMEOUT_CYCLES  grant-wait limit in cycles, legal 2..255; only has an
//                   effect when MEMACC_TIMEOUT_EN is defined.
//
// Build option:
//   MEMACC_TIMEOUT_EN  when defined, a request waiting TIMEOUT_CYCLES cycles
//                      without grant is dropped and bus_err_o pulses once.
//                      When undefined the stage waits for grant indefinitely
//                      and bus_err_o is tied to 0.
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   req_valid_i  in   execute presents a memory op this cycle
//   re_i         in   op is a load
//   we_i         in   op is a store (wins over re_i)
//   scope_i      in   2'b00 byte, 2'b01 half, 2'b11 word, 2'b10 illegal
//   signed_i     in   load sign-extends
//   addr_i       in   byte address
//   wdata_i      in   store data, right-justified
//   mem          bus  memacc_tx_if.master (req/we/addr/be/wdata out, gnt in)
//   ren_o        out  to memacc_rx: read data due this cycle (one-cycle pulse)
//   scope_o      out  to memacc_rx: scope of the granted load
//   signed_o     out  to memacc_rx: sign flag of the granted load
//   addr_lsb2_o  out  to memacc_rx: byte offset of the granted load
//   misalign_o   out  one-cycle pulse: misaligned/illegal op dropped
//   bad_addr_o   out  offending address, valid with misalign_o
//   bus_err_o    out  one-cycle pulse: grant timeout
//   stall_req_o  out  freeze upstream pipeline (combinational)
// -----------------------------------------------------------------------------
module memacc_tx #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         req_valid_i,
    input  logic         re_i,
    input  logic         we_i,
    input  logic [1:0]   scope_i,
    input  logic         signed_i,
    input  logic [31:0]  addr_i,
    input  logic [31:0]  wdata_i,

    memacc_tx_if.master  mem,

    output logic         ren_o,
    output logic [1:0]   scope_o,
    output logic         signed_o,
    output logic [1:0]   addr_lsb2_o,
    output logic         misalign_o,
    output logic [31:0]  bad_addr_o,
    output logic         bus_err_o,
    output logic         stall_req_o
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    localparam logic [1:0] SCOPE_BYTE = 2'b00;
    localparam logic [1:0] SCOPE_HALF = 2'b01;
    localparam logic [1:0] SCOPE_WORD = 2'b11;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("memacc_tx: TIMEOUT_CYCLES must lie in 2..255");
    end

    state_t      state;

    // Sideband of the request currently on the bus, forwarded to memacc_rx
    // only once a load is granted.
    logic [1:0]  cur_scope;
    logic        cur_signed;
    logic [1:0]  cur_lsb2;

    logic        granted;
    logic        can_accept;
    logic        accept;
    logic        aligned;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;

    // -------------------------------------------------------------------------
    // Request decode: alignment, byte enables and lane placement
    // -------------------------------------------------------------------------
    assign granted    = (state == REQ) && mem.gnt;
    assign can_accept = (state == IDLE) || granted;
    assign accept     = req_valid_i && (re_i || we_i) && can_accept;

    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        aligned    = 1'b0;
        be_next    = 4'b0000;
        wdata_next = wdata_i;
        unique case (scope_i)
            SCOPE_BYTE: begin
                aligned    = 1'b1;
                // Big endian: byte offset 0 lives in bits [31:24].
                be_next    = 4'b1000 >> addr_i[1:0];
                wdata_next = {4{wdata_i[7:0]}};
            end
            SCOPE_HALF: begin
                aligned    = ~addr_i[0];
                be_next    = addr_i[1] ? 4'b0011 : 4'b1100;
                wdata_next = {2{wdata_i[15:0]}};
            end
            SCOPE_WORD: begin
                aligned    = (addr_i[1:0] == 2'b00);
                be_next    = 4'b1111;
                wdata_next = wdata_i;
            end
            default: begin
                // scope 2'b10 is never a legal access
                aligned    = 1'b0;
                be_next    = 4'b0000;
                wdata_next = wdata_i;
            end
        endcase
    end

    // Upstream must hold while a request is outstanding and not being granted.
    assign stall_req_o = (state == REQ) && !mem.gnt;

    // -------------------------------------------------------------------------
    // Request FSM with registered bus and sideband outputs
    // -------------------------------------------------------------------------
`ifdef MEMACC_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tmo_cnt;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the bus and sideband registers are reset as well as the
            // control state, because a reset mid-wait must leave the bus idle
            // and every output at 0 immediately, not after the next edge.
            state       <= IDLE;
            mem.req     <= 1'b0;
            mem.we      <= 1'b0;
            mem.addr    <= '0;
            mem.be      <= '0;
            mem.wdata   <= '0;
            cur_scope   <= '0;
            cur_signed  <= 1'b0;
            cur_lsb2    <= '0;
            ren_o       <= 1'b0;
            scope_o     <= '0;
            signed_o    <= 1'b0;
            addr_lsb2_o <= '0;
            misalign_o  <= 1'b0;
            bad_addr_o  <= '0;
`ifdef MEMACC_TIMEOUT_EN
            bus_err_o   <= 1'b0;
            tmo_cnt     <= '0;
`endif
        end else begin
            ren_o      <= 1'b0;
            misalign_o <= 1'b0;
`ifdef MEMACC_TIMEOUT_EN
            bus_err_o  <= 1'b0;
`endif

            if (granted) begin
                state   <= IDLE;
                mem.req <= 1'b0;
                // Read data returns the cycle after a load grant; the sideband
                // is refreshed only then and otherwise keeps its last value.
                if (!mem.we) begin
                    ren_o       <= 1'b1;
                    scope_o     <= cur_scope;
                    signed_o    <= cur_signed;
                    addr_lsb2_o <= cur_lsb2;
                end
            end
`ifdef MEMACC_TIMEOUT_EN
            else if (state == REQ) begin
                if (tmo_cnt == TMO_LAST) begin
                    state     <= IDLE;
                    mem.req   <= 1'b0;
                    bus_err_o <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                end
            end
`endif

            // A new op accepted in the grant cycle overrides the return to
            // IDLE above, giving one request per cycle back-to-back.
            if (accept) begin
                if (aligned) begin
                    state      <= REQ;
                    mem.req    <= 1'b1;
                    mem.we     <= we_i;
                    mem.addr   <= {addr_i[31:2], 2'b00};
                    mem.be     <= be_next;
                    mem.wdata  <= wdata_next;
                    cur_scope  <= scope_i;
                    cur_signed <= signed_i;
                    cur_lsb2   <= addr_i[1:0];
`ifdef MEMACC_TIMEOUT_EN
                    tmo_cnt    <= '0;
`endif
                end else begin
                    misalign_o <= 1'b1;
                    bad_addr_o <= addr_i;
                end
            end
        end
    end

`ifndef MEMACC_TIMEOUT_EN
    assign bus_err_o = 1'b0;
`endif

endmodule : memacc_tx

// File: tb/tb_memacc_tx.sv
// -----------------------------------------------------------------------------
// tb_memacc_tx
// Directed stimulus for memacc_tx. Each issued op pushes its hand-computed
// expected bus request, read sideband or misalign report into a queue; a
// monitor on the falling clock edge pops and compares whenever the DUT
// presents a granted request, ren_o, misalign_o or bus_err_o.
// -----------------------------------------------------------------------------
module tb_memacc_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_i;
    logic        re_i;
    logic        we_i;
    logic [1:0]  scope_i;
    logic        signed_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        ren_o;
    logic [1:0]  scope_o;
    logic        signed_o;
    logic [1:0]  addr_lsb2_o;
    logic        misalign_o;
    logic [31:0] bad_addr_o;
    logic        bus_err_o;
    logic        stall_req_o;

    memacc_tx_if mem_if ();

    memacc_tx #(.TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid_i),
        .re_i        (re_i),
        .we_i        (we_i),
        .scope_i     (scope_i),
        .signed_i    (signed_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .mem         (mem_if.master),
        .ren_o       (ren_o),
        .scope_o     (scope_o),
        .signed_o    (signed_o),
        .addr_lsb2_o (addr_lsb2_o),
        .misalign_o  (misalign_o),
        .bad_addr_o  (bad_addr_o),
        .bus_err_o   (bus_err_o),
        .stall_req_o (stall_req_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic [1:0] scope;
        logic       sgn;
        logic [1:0] lsb2;
    } rd_t;

    req_t        exp_req_q[$];
    rd_t         exp_rd_q[$];
    logic [31:0] exp_mis_q[$];
    int          exp_berr = 0;

    int n_cmp = 0;
    int n_err = 0;

    req_t        mon_req;
    rd_t         mon_rd;
    logic [31:0] mon_mis;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_cmp++;
        n_err++;
        $display("FAIL %s: unexpected output, value 0x%08h, expected none (t=%0t)", name, act, $time);
    endtask

    // ---------------------------------------------------------------- monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_if.req && mem_if.gnt) begin
                if (exp_req_q.size() == 0) begin
                    unexpected("mem_req", mem_if.addr);
                end else begin
                    mon_req = exp_req_q.pop_front();
                    check("mem_we",   32'(mem_if.we),   32'(mon_req.we));
                    check("mem_addr", mem_if.addr,      mon_req.addr);
                    check("mem_be",   32'(mem_if.be),   32'(mon_req.be));
                    if (mon_req.we) check("mem_wdata", mem_if.wdata, mon_req.wdata);
                end
            end
            if (ren_o) begin
                if (exp_rd_q.size() == 0) begin
                    unexpected("ren", 32'(addr_lsb2_o));
                end else begin
                    mon_rd = exp_rd_q.pop_front();
                    check("rd_scope",  32'(scope_o),     32'(mon_rd.scope));
                    check("rd_signed", 32'(signed_o),    32'(mon_rd.sgn));
                    check("rd_lsb2",   32'(addr_lsb2_o), 32'(mon_rd.lsb2));
                end
            end
            if (misalign_o) begin
                if (exp_mis_q.size() == 0) begin
                    unexpected("misalign", bad_addr_o);
                end else begin
                    mon_mis = exp_mis_q.pop_front();
                    check("bad_addr", bad_addr_o, mon_mis);
                end
            end
            if (bus_err_o) begin
                if (exp_berr == 0) begin
                    unexpected("bus_err", 32'(mem_if.req));
                end else begin
                    exp_berr--;
                    check("bus_err_stall", 32'(stall_req_o), 32'd0);
                end
            end
        end
    end

    // ------------------------------------------------------------- stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid_i = 1'b0;
        re_i        = 1'b0;
        we_i        = 1'b0;
        scope_i     = 2'b00;
        signed_i    = 1'b0;
        addr_i      = '0;
        wdata_i     = '0;
    endtask

    task automatic drive_op(input logic re, input logic we, input logic [1:0] sc,
                            input logic sg, input logic [31:0] a, input logic [31:0] wd);
        req_valid_i = 1'b1;
        re_i        = re;
        we_i        = we;
        scope_i     = sc;
        signed_i    = sg;
        addr_i      = a;
        wdata_i     = wd;
    endtask

    // Issue one op (caller sits just after a rising edge), grant it after
    // wait_cyc stalled cycles, and check stall behaviour along the way.
    task automatic mem_op(input logic re, input logic we, input logic [1:0] sc,
                          input logic sg, input logic [31:0] a, input logic [31:0] wd,
                          input logic ok, input logic [31:0] eaddr, input logic [3:0] ebe,
                          input logic [31:0] ewd, input int wait_cyc);
        req_t er;
        rd_t  ed;
        mem_if.gnt = 1'b0;
        drive_op(re, we, sc, sg, a, wd);
        if (ok) begin
            er = '{we: we, addr: eaddr, be: ebe, wdata: ewd};
            exp_req_q.push_back(er);
            if (!we) begin
                ed = '{scope: sc, sgn: sg, lsb2: a[1:0]};
                exp_rd_q.push_back(ed);
            end
        end else begin
            exp_mis_q.push_back(a);
        end
        tick();
        idle_inputs();
        if (ok) begin
            for (int i = 0; i < wait_cyc; i++) begin
                @(negedge clk);
                check("stall_wait", 32'(stall_req_o), 32'd1);
                tick();
            end
            mem_if.gnt = 1'b1;
            @(negedge clk);
            check("stall_on_gnt", 32'(stall_req_o), 32'd0);
            tick();
            mem_if.gnt = 1'b0;
        end else begin
            @(negedge clk);
            check("no_req_illegal", 32'(mem_if.req), 32'd0);
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  req_cycles;
        bit  seen;

        idle_inputs();
        mem_if.gnt = 1'b0;
        rst_n      = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", 32'(mem_if.req), 32'd0);
        check("rst_stall",   32'(stall_req_o), 32'd0);
        check("rst_ren",     32'(ren_o), 32'd0);
        check("rst_mis",     32'(misalign_o), 32'd0);
        check("rst_berr",    32'(bus_err_o), 32'd0);
        check("rst_be",      32'(mem_if.be), 32'd0);
        rst_n = 1'b1;
        tick();

        // Load byte signed @0x1003, grant in the first request cycle
        mem_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0,
               1'b1, 32'h0000_1000, 4'b0001, 32'h0, 0);
        // Store half 0xBEEF @0x2002, grant after 3 stalled cycles
        mem_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_BEEF,
               1'b1, 32'h0000_2000, 4'b0011, 32'hBEEF_BEEF, 3);
        // Illegal: word @0x3001, scope 10 @0x3000, half store @0x4001
        mem_op(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_3001, 32'h0,
               1'b0, 32'h0, 4'b0, 32'h0, 0);
        mem_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_3000, 32'h0,
               1'b0, 32'h0, 4'b0, 32'h0, 0);
        mem_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_4001, 32'h1234,
               1'b0, 32'h0, 4'b0, 32'h0, 0);
        // Half load unsigned @0x4000, byte store @0x5002, half store @0x5000
        mem_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_4000, 32'h0,
               1'b1, 32'h0000_4000, 4'b1100, 32'h0, 1);
        mem_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_5002, 32'h1234_56A5,
               1'b1, 32'h0000_5000, 4'b0010, 32'hA5A5_A5A5, 2);
        mem_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_5000, 32'hFFFF_1234,
               1'b1, 32'h0000_5000, 4'b1100, 32'h1234_1234, 0);
        // re and we both set: behaves as a word store
        mem_op(1'b1, 1'b1, 2'b11, 1'b1, 32'h0000_7004, 32'hCAFE_F00D,
               1'b1, 32'h0000_7004, 4'b1111, 32'hCAFE_F00D, 1);

        // req_valid with neither re nor we: ignored
        drive_op(1'b0, 1'b0, 2'b11, 1'b0, 32'h0000_9000, 32'h0);
        mem_if.gnt = 1'b1;
        tick();
        idle_inputs();
        @(negedge clk);
        check("ignored_no_req", 32'(mem_if.req), 32'd0);
        tick();
        mem_if.gnt = 1'b0;

        // Back-to-back: word store @0x10 then byte load @0x21, gnt every cycle
        mem_if.gnt = 1'b1;
        drive_op(1'b0, 1'b1, 2'b11, 1'b0, 32'h0000_0010, 32'h1122_3344);
        exp_req_q.push_back('{we: 1'b1, addr: 32'h0000_0010, be: 4'b1111, wdata: 32'h1122_3344});
        tick();
        drive_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0021, 32'h0);
        exp_req_q.push_back('{we: 1'b0, addr: 32'h0000_0020, be: 4'b0100, wdata: 32'h0});
        exp_rd_q.push_back('{scope: 2'b00, sgn: 1'b0, lsb2: 2'b01});
        @(negedge clk);
        check("b2b_stall_1", 32'(stall_req_o), 32'd0);
        tick();
        idle_inputs();
        @(negedge clk);
        check("b2b_req_2", 32'(mem_if.req), 32'd1);
        check("b2b_stall_2", 32'(stall_req_o), 32'd0);
        tick();
        mem_if.gnt = 1'b0;
        tick();

        // Reset while waiting for grant aborts the request silently
        drive_op(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_6000, 32'h0);
        tick();
        idle_inputs();
        tick();
        @(negedge clk);
        check("pre_rst_stall", 32'(stall_req_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_req",   32'(mem_if.req), 32'd0);
        check("rst_mid_stall", 32'(stall_req_o), 32'd0);
        tick();
        rst_n      = 1'b1;
        mem_if.gnt = 1'b1;
        repeat (3) tick();
        check("post_rst_req", 32'(mem_if.req), 32'd0);
        mem_if.gnt = 1'b0;

        // Grant never arrives
        drive_op(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_8000, 32'h0);
        tick();
        idle_inputs();
`ifdef MEMACC_TIMEOUT_EN
        exp_berr   = 1;
        req_cycles = 0;
        seen       = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus_err_o) seen = 1'b1;
            else if (mem_if.req) req_cycles++;
        end
        check("tmo_seen",       32'(seen), 32'd1);
        check("tmo_req_cycles", 32'(req_cycles), 32'd4);
        check("tmo_req_drop",   32'(mem_if.req), 32'd0);
        tick();
`else
        req_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (stall_req_o && mem_if.req) req_cycles++;
        end
        check("wait_forever", 32'(req_cycles), 32'd20);
        #2;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
`endif

        repeat (3) tick();
        check("req_q_empty",  32'(exp_req_q.size()), 32'd0);
        check("rd_q_empty",   32'(exp_rd_q.size()),  32'd0);
        check("mis_q_empty",  32'(exp_mis_q.size()), 32'd0);
        check("berr_pending", 32'(exp_berr),         32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_memacc_tx
